// File: rtl/n2_mu_issue_if.sv
// Decode request, mul/div unit pins, writeback port and scoreboard query of n2_mu_issue.
// The slave modport is the controller; the master modport is its environment.
interface n2_mu_issue_if #(
    parameter int unsigned REGIDX_BITS = 5,
    parameter int unsigned UID_BITS    = 8
);
    logic                   req_valid_i;
    logic                   req_ready_o;
    logic [UID_BITS-1:0]    req_uid_i;
    logic [3:0]             req_mul_op_i;
    logic [3:0]             req_div_op_i;
    logic [31:0]            req_rs1_i;
    logic [31:0]            req_rs2_i;
    logic [REGIDX_BITS-1:0] req_dst_i;
    logic                   flush_i;
    logic                   mul_div_v_o;
    logic [UID_BITS-1:0]    uid_d2_o;
    logic [3:0]             mul_op_o;
    logic [3:0]             div_op_o;
    logic [31:0]            mu_rs1_o;
    logic [31:0]            mu_rs2_o;
    logic [REGIDX_BITS-1:0] rf_dst_idu_o;
    logic                   rf_we_mu_i;
    logic [31:0]            alu_rst_mu_i;
    logic [UID_BITS-1:0]    uid_mu_i;
    logic                   wb_valid_o;
    logic                   wb_ready_i;
    logic [REGIDX_BITS-1:0] wb_dst_o;
    logic [31:0]            wb_data_o;
    logic [UID_BITS-1:0]    wb_uid_o;
    logic [REGIDX_BITS-1:0] hz_rs1_idx_i;
    logic [REGIDX_BITS-1:0] hz_rs2_idx_i;
    logic                   hazard_o;
    logic                   err_o;

    modport slave (
        input  req_valid_i, req_uid_i, req_mul_op_i, req_div_op_i, req_rs1_i, req_rs2_i,
               req_dst_i, flush_i, rf_we_mu_i, alu_rst_mu_i, uid_mu_i, wb_ready_i,
               hz_rs1_idx_i, hz_rs2_idx_i,
        output req_ready_o, mul_div_v_o, uid_d2_o, mul_op_o, div_op_o, mu_rs1_o, mu_rs2_o,
               rf_dst_idu_o, wb_valid_o, wb_dst_o, wb_data_o, wb_uid_o, hazard_o, err_o
    );

    modport master (
        output req_valid_i, req_uid_i, req_mul_op_i, req_div_op_i, req_rs1_i, req_rs2_i,
               req_dst_i, flush_i, rf_we_mu_i, alu_rst_mu_i, uid_mu_i, wb_ready_i,
               hz_rs1_idx_i, hz_rs2_idx_i,
        input  req_ready_o, mul_div_v_o, uid_d2_o, mul_op_o, div_op_o, mu_rs1_o, mu_rs2_o,
               rf_dst_idu_o, wb_valid_o, wb_dst_o, wb_data_o, wb_uid_o, hazard_o, err_o
    );
endinterface

// File: rtl/n2_mu_issue.sv
// Mul/div issue and writeback controller: one op in flight, 2-entry writeback FIFO,
// destination scoreboard for decode stalls.
module n2_mu_issue #(
    parameter int unsigned REGIDX_BITS = 5,
    parameter int unsigned UID_BITS    = 8
) (
    input  logic          clk,
    input  logic          resetn,
    n2_mu_issue_if.slave  bus
);
    localparam int unsigned DATA_BITS = 32;
    localparam int unsigned OP_BITS   = 4;

    typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;

    typedef struct packed {
        logic [REGIDX_BITS-1:0] dst;
        logic [DATA_BITS-1:0]   data;
        logic [UID_BITS-1:0]    uid;
    } wb_entry_t;

    state_t                 state_q, state_d;
    logic                   pend_q, killed_q, err_q;
    logic [REGIDX_BITS-1:0] inf_dst_q;
    logic [UID_BITS-1:0]    inf_uid_q;

    logic                   mdv_q;
    logic [UID_BITS-1:0]    iss_uid_q;
    logic [OP_BITS-1:0]     iss_mul_q, iss_div_q;
    logic [DATA_BITS-1:0]   iss_rs1_q, iss_rs2_q;
    logic [REGIDX_BITS-1:0] iss_dst_q;

    wb_entry_t              fifo_q [2];
    logic [1:0]             count_q;
    wb_entry_t              new_c;

    logic ready_c, accept_c, issue_c, bad_req_c, result_c, stray_c;
    logic push_c, pop_c, uid_err_c, hazard_c;

    function automatic logic dst_hit(
        input logic [REGIDX_BITS-1:0] idx,
        input logic                   pend,
        input logic [REGIDX_BITS-1:0] inf_dst,
        input logic [1:0]             vld,
        input logic [REGIDX_BITS-1:0] d0,
        input logic [REGIDX_BITS-1:0] d1
    );
        return (idx != '0) &&
               ((pend && idx == inf_dst) || (vld[0] && idx == d0) || (vld[1] && idx == d1));
    endfunction

    assign ready_c   = (state_q == IDLE) && (count_q < 2'd2) && !bus.flush_i;
    assign accept_c  = bus.req_valid_i && ready_c;
    assign push_c    = result_c && !killed_q;
    assign pop_c     = (count_q != 2'd0) && bus.wb_ready_i;
    assign uid_err_c = result_c && (bus.uid_mu_i != inf_uid_q);
    assign new_c     = '{dst: inf_dst_q, data: bus.alu_rst_mu_i, uid: inf_uid_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state and per-cycle control decode.
    always_comb begin
        state_d   = state_q;
        issue_c   = 1'b0;
        bad_req_c = 1'b0;
        result_c  = 1'b0;
        stray_c   = 1'b0;
        case (state_q)
            IDLE: begin
                stray_c = bus.rf_we_mu_i;
                if (accept_c) begin
                    if ((|bus.req_mul_op_i) ^ (|bus.req_div_op_i)) begin
                        issue_c = 1'b1;
                        state_d = (|bus.req_mul_op_i) ? MUL_WAIT : DIV_WAIT;
                    end else begin
                        bad_req_c = 1'b1;
                    end
                end
            end
            MUL_WAIT, DIV_WAIT: begin
                if (bus.rf_we_mu_i) begin
                    result_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // In-flight tracking; a flush only marks the op so its late result is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q    <= 1'b0;
            killed_q  <= 1'b0;
            err_q     <= 1'b0;
            inf_dst_q <= '0;
            inf_uid_q <= '0;
        end else begin
            err_q <= bad_req_c | stray_c | uid_err_c;
            if (issue_c) begin
                pend_q    <= 1'b1;
                killed_q  <= 1'b0;
                inf_dst_q <= bus.req_dst_i;
                inf_uid_q <= bus.req_uid_i;
            end else if (result_c) begin
                pend_q   <= 1'b0;
                killed_q <= 1'b0;
            end else if (bus.flush_i && state_q != IDLE) begin
                pend_q   <= 1'b0;
                killed_q <= 1'b1;
            end
        end
    end

    // Unit request pins: single-cycle valid, payload held until the next issue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdv_q     <= 1'b0;
            iss_uid_q <= '0;
            iss_mul_q <= '0;
            iss_div_q <= '0;
            iss_rs1_q <= '0;
            iss_rs2_q <= '0;
            iss_dst_q <= '0;
        end else begin
            mdv_q <= issue_c;
            if (issue_c) begin
                iss_uid_q <= bus.req_uid_i;
                iss_mul_q <= bus.req_mul_op_i;
                iss_div_q <= bus.req_div_op_i;
                iss_rs1_q <= bus.req_rs1_i;
                iss_rs2_q <= bus.req_rs2_i;
                iss_dst_q <= bus.req_dst_i;
            end
        end
    end

    // Writeback FIFO; entry 0 is the registered head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            case ({push_c, pop_c})
                2'b10: begin
                    if (count_q == 2'd0) fifo_q[0] <= new_c;
                    else                 fifo_q[1] <= new_c;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    fifo_q[0] <= fifo_q[1];
                    count_q   <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        fifo_q[0] <= new_c;
                    end else begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= new_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        hazard_c = 1'b0;
        if (dst_hit(bus.hz_rs1_idx_i, pend_q, inf_dst_q, {count_q == 2'd2, count_q != 2'd0},
                    fifo_q[0].dst, fifo_q[1].dst))
            hazard_c = 1'b1;
        if (dst_hit(bus.hz_rs2_idx_i, pend_q, inf_dst_q, {count_q == 2'd2, count_q != 2'd0},
                    fifo_q[0].dst, fifo_q[1].dst))
            hazard_c = 1'b1;
    end

    assign bus.req_ready_o  = ready_c;
    assign bus.hazard_o     = hazard_c;
    assign bus.err_o        = err_q;
    assign bus.mul_div_v_o  = mdv_q;
    assign bus.uid_d2_o     = iss_uid_q;
    assign bus.mul_op_o     = iss_mul_q;
    assign bus.div_op_o     = iss_div_q;
    assign bus.mu_rs1_o     = iss_rs1_q;
    assign bus.mu_rs2_o     = iss_rs2_q;
    assign bus.rf_dst_idu_o = iss_dst_q;
    assign bus.wb_valid_o   = (count_q != 2'd0);
    assign bus.wb_dst_o     = fifo_q[0].dst;
    assign bus.wb_data_o    = fifo_q[0].data;
    assign bus.wb_uid_o     = fifo_q[0].uid;
endmodule

// File: tb/tb_n2_mu_issue.sv
// Bench for n2_mu_issue: emulates the mul/div unit, keeps a queue-level model of the
// controller and checks every cycle, plus hand-computed directed expectations.
module tb_n2_mu_issue;
    localparam int unsigned RB = 5;
    localparam int unsigned UB = 8;
    localparam logic [3:0]  OP_MUL  = 4'b1000;
    localparam logic [3:0]  OP_DIV  = 4'b1000;
    localparam logic [3:0]  OP_NONE = 4'b0000;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    n2_mu_issue_if #(.REGIDX_BITS(RB), .UID_BITS(UB)) b ();
    n2_mu_issue #(.REGIDX_BITS(RB), .UID_BITS(UB)) dut (.clk(clk), .resetn(resetn), .bus(b));

    int n_vec  = 0;
    int n_miss = 0;
    int n_pulse = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- mul/div unit stand-in ----------------
    function automatic logic [31:0] unit_calc(input logic [3:0] mo, input logic [3:0] dop,
                                              input logic [31:0] a, input logic [31:0] c);
        longint sa, sc;
        longint unsigned ua, uc;
        sa = longint'($signed(a));
        sc = longint'($signed(c));
        ua = {32'd0, a};
        uc = {32'd0, c};
        if (mo[3]) return 32'(sa * sc);
        if (mo[2]) return 32'((sa * sc) >>> 32);
        if (mo[1]) return 32'((sa * longint'(uc)) >>> 32);
        if (mo[0]) return 32'((ua * uc) >> 32);
        if (c == 32'd0) return (dop[3] || dop[2]) ? 32'hFFFF_FFFF : a;
        if (dop[3]) return 32'(sa / sc);
        if (dop[2]) return 32'(ua / uc);
        if (dop[1]) return 32'(sa % sc);
        return 32'(ua % uc);
    endfunction

    int            u_cnt;
    logic [31:0]   u_res;
    logic [UB-1:0] u_uid;
    logic [UB-1:0] u_flip;

    initial begin
        b.rf_we_mu_i   = 1'b0;
        b.alu_rst_mu_i = '0;
        b.uid_mu_i     = '0;
        u_cnt = 0;
        u_res = '0;
        u_uid = '0;
        forever begin
            @(posedge clk); #1;
            b.rf_we_mu_i = 1'b0;
            if (!resetn) begin
                u_cnt = 0;
            end else begin
                if (u_cnt > 0) begin
                    u_cnt--;
                    if (u_cnt == 0) begin
                        b.rf_we_mu_i   = 1'b1;
                        b.alu_rst_mu_i = u_res;
                        b.uid_mu_i     = u_uid ^ u_flip;
                    end
                end
                if (b.mul_div_v_o) begin
                    u_res = unit_calc(b.mul_op_o, b.div_op_o, b.mu_rs1_o, b.mu_rs2_o);
                    u_uid = b.uid_d2_o;
                    u_cnt = (b.mul_op_o != 4'd0) ? 2 : 34;
                end
            end
        end
    end

    always @(negedge clk) if (resetn && b.mul_div_v_o) n_pulse++;

    // ---------------- behavioural model ----------------
    typedef struct { logic [RB-1:0] dst; logic [31:0] data; logic [UB-1:0] uid; } wb_t;
    typedef struct { logic [UB-1:0] uid; logic [3:0] mo; logic [3:0] dop;
                     logic [31:0] rs1; logic [31:0] rs2; logic [RB-1:0] dst; } iss_t;

    wb_t           q[$];
    iss_t          m_last;
    bit            m_busy, m_pend, m_killed, m_issue, m_err, m_rdy, m_one;
    logic [RB-1:0] m_dst;
    logic [UB-1:0] m_uid;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            m_busy = 0; m_pend = 0; m_killed = 0; m_issue = 0; m_err = 0;
            m_dst = '0; m_uid = '0;
            m_last = '{uid: '0, mo: '0, dop: '0, rs1: '0, rs2: '0, dst: '0};
        end else begin
            m_rdy   = !m_busy && q.size() < 2 && !b.flush_i;
            m_one   = (b.req_mul_op_i != 4'd0) != (b.req_div_op_i != 4'd0);
            m_issue = 0;
            m_err   = 0;
            if (b.wb_ready_i && q.size() > 0) void'(q.pop_front());
            if (b.rf_we_mu_i) begin
                if (!m_busy) m_err = 1;
                else begin
                    if (b.uid_mu_i != m_uid) m_err = 1;
                    if (!m_killed) q.push_back('{dst: m_dst, data: b.alu_rst_mu_i, uid: m_uid});
                    m_busy = 0; m_pend = 0; m_killed = 0;
                end
            end else if (m_busy && b.flush_i) begin
                m_killed = 1; m_pend = 0;
            end
            if (b.req_valid_i && m_rdy) begin
                if (m_one) begin
                    m_busy = 1; m_pend = 1; m_killed = 0;
                    m_dst = b.req_dst_i; m_uid = b.req_uid_i; m_issue = 1;
                    m_last = '{uid: b.req_uid_i, mo: b.req_mul_op_i, dop: b.req_div_op_i,
                               rs1: b.req_rs1_i, rs2: b.req_rs2_i, dst: b.req_dst_i};
                end else begin
                    m_err = 1;
                end
            end
        end
    end

    function automatic bit m_hz(input logic [RB-1:0] idx);
        bit h = 0;
        if (idx != '0) begin
            if (m_pend && idx == m_dst) h = 1;
            foreach (q[i]) if (q[i].dst == idx) h = 1;
        end
        return h;
    endfunction

    // Per-cycle comparison against the model, or against reset values while in reset.
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_mdv", b.mul_div_v_o, 0);
            chk("rst_wb_valid", b.wb_valid_o, 0);
            chk("rst_hazard", b.hazard_o, 0);
            chk("rst_err", b.err_o, 0);
            chk("rst_ready", b.req_ready_o, !b.flush_i);
            chk("rst_uid_d2", b.uid_d2_o, 0);
            chk("rst_wb_data", b.wb_data_o, 0);
        end else begin
            chk("ready", b.req_ready_o, !m_busy && q.size() < 2 && !b.flush_i);
            chk("hazard", b.hazard_o, m_hz(b.hz_rs1_idx_i) || m_hz(b.hz_rs2_idx_i));
            chk("issue", b.mul_div_v_o, m_issue);
            chk("err", b.err_o, m_err);
            chk("pin_uid", b.uid_d2_o, m_last.uid);
            chk("pin_ops", {b.mul_op_o, b.div_op_o}, {m_last.mo, m_last.dop});
            chk("pin_rs", {b.mu_rs1_o, b.mu_rs2_o}, {m_last.rs1, m_last.rs2});
            chk("pin_dst", b.rf_dst_idu_o, m_last.dst);
            chk("wb_valid", b.wb_valid_o, q.size() != 0);
            if (q.size() != 0) chk("wb_head", {b.wb_dst_o, b.wb_data_o, b.wb_uid_o},
                                   {q[0].dst, q[0].data, q[0].uid});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [UB-1:0] uid, input logic [3:0] mo, input logic [3:0] dop,
                       input logic [31:0] a, input logic [31:0] c, input logic [RB-1:0] dst);
        b.req_valid_i  = 1'b1;
        b.req_uid_i    = uid;
        b.req_mul_op_i = mo;
        b.req_div_op_i = dop;
        b.req_rs1_i    = a;
        b.req_rs2_i    = c;
        b.req_dst_i    = dst;
        step();
        b.req_valid_i  = 1'b0;
    endtask

    task automatic wait_wb(input int lim);
        int i = 0;
        @(negedge clk);
        while (!b.wb_valid_o && i < lim) begin @(negedge clk); i++; end
        chk("wb_wait_timeout", b.wb_valid_o, 1);
    endtask

    task automatic wait_rfwe(input int lim);
        int i = 0;
        @(negedge clk);
        while (!b.rf_we_mu_i && i < lim) begin @(negedge clk); i++; end
        chk("rfwe_wait_timeout", b.rf_we_mu_i, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    int p0;
    initial begin
        resetn = 1'b0;
        u_flip = '0;
        b.req_valid_i = 1'b0; b.req_uid_i = '0; b.req_mul_op_i = '0; b.req_div_op_i = '0;
        b.req_rs1_i = '0; b.req_rs2_i = '0; b.req_dst_i = '0; b.flush_i = 1'b0;
        b.wb_ready_i = 1'b1; b.hz_rs1_idx_i = '0; b.hz_rs2_idx_i = '0;
        step(3);
        @(negedge clk); resetn = 1'b1;
        step(2);

        // MUL 7 * -3 -> 0xFFFFFFEB, writeback 4 cycles after accept
        b.hz_rs1_idx_i = 5'd5;
        req(8'h11, OP_MUL, OP_NONE, 32'd7, 32'hFFFF_FFFD, 5'd5);
        @(negedge clk); chk("t1_issue", b.mul_div_v_o, 1); chk("t1_hz_pend", b.hazard_o, 1);
        step(2);
        @(negedge clk); chk("t1_busy_ready", b.req_ready_o, 0); chk("t1_hz_t3", b.hazard_o, 1);
        step();
        @(negedge clk);
        chk("t1_wb_valid", b.wb_valid_o, 1);
        chk("t1_wb_data", b.wb_data_o, 32'hFFFF_FFEB);
        chk("t1_wb_dst", b.wb_dst_o, 5);
        chk("t1_wb_uid", b.wb_uid_o, 8'h11);
        chk("t1_hz_fifo", b.hazard_o, 1);
        chk("t1_ready_t4", b.req_ready_o, 1);
        step();
        @(negedge clk); chk("t1_drained", b.wb_valid_o, 0); chk("t1_hz_clear", b.hazard_o, 0);
        step();

        // DIV -20 / 3 -> 0xFFFFFFFA, exactly one issue pulse
        p0 = n_pulse;
        b.hz_rs1_idx_i = 5'd6;
        req(8'h22, OP_NONE, OP_DIV, 32'hFFFF_FFEC, 32'd3, 5'd6);
        wait_wb(60);
        chk("t2_wb_data", b.wb_data_o, 32'hFFFF_FFFA);
        chk("t2_wb_dst", b.wb_dst_o, 6);
        chk("t2_pulses", n_pulse - p0, 1);
        step();

        // two MULs into a stalled writeback port, then an in-order drain
        b.wb_ready_i = 1'b0; b.hz_rs1_idx_i = 5'd7; b.hz_rs2_idx_i = 5'd8;
        req(8'h31, OP_MUL, OP_NONE, 32'd3, 32'd4, 5'd7); step(4);
        req(8'h32, OP_MUL, OP_NONE, 32'd5, 32'd6, 5'd8); step(4);
        @(negedge clk); chk("t3_full_ready", b.req_ready_o, 0); chk("t3_hz", b.hazard_o, 1);
        step();
        req(8'h33, OP_MUL, OP_NONE, 32'd9, 32'd9, 5'd9);
        @(negedge clk); chk("t3_no_issue", b.mul_div_v_o, 0); chk("t3_pin_hold", b.uid_d2_o, 8'h32);
        step();
        b.wb_ready_i = 1'b1;
        @(negedge clk); chk("t3_head0", {b.wb_dst_o, b.wb_data_o, b.wb_uid_o}, {5'd7, 32'd12, 8'h31});
        step();
        @(negedge clk); chk("t3_head1", {b.wb_dst_o, b.wb_data_o, b.wb_uid_o}, {5'd8, 32'd30, 8'h32});
        step();
        @(negedge clk); chk("t3_empty", b.wb_valid_o, 0);
        step();

        // flush one cycle after a DIV issue: result discarded
        b.hz_rs1_idx_i = 5'd9; b.hz_rs2_idx_i = 5'd0;
        req(8'h41, OP_NONE, OP_DIV, 32'd100, 32'd7, 5'd9);
        @(negedge clk); chk("t4_hz_pend", b.hazard_o, 1);
        step(); b.flush_i = 1'b1;
        @(negedge clk); chk("t4_flush_ready", b.req_ready_o, 0);
        step(); b.flush_i = 1'b0;
        @(negedge clk); chk("t4_hz_drop", b.hazard_o, 0);
        wait_rfwe(60);
        chk("t4_ready_at_result", b.req_ready_o, 0);
        step();
        @(negedge clk); chk("t4_no_push", b.wb_valid_o, 0); chk("t4_ready_back", b.req_ready_o, 1);
        step();

        // malformed requests and a returned uid mismatch
        p0 = n_pulse;
        req(8'h51, 4'b0001, 4'b1000, 32'd1, 32'd1, 5'd3);
        @(negedge clk); chk("t5_both_err", b.err_o, 1); chk("t5_both_noissue", b.mul_div_v_o, 0);
        step();
        @(negedge clk); chk("t5_err_pulse", b.err_o, 0);
        step();
        req(8'h52, OP_NONE, OP_NONE, 32'd1, 32'd1, 5'd3);
        @(negedge clk); chk("t5_none_err", b.err_o, 1); chk("t5_pulses", n_pulse - p0, 0);
        step();
        u_flip = 8'hFF;
        req(8'h53, OP_MUL, OP_NONE, 32'd2, 32'd2, 5'd10);
        step(3);
        @(negedge clk);
        chk("t5_uid_err", b.err_o, 1);
        chk("t5_uid_kept", {b.wb_valid_o, b.wb_uid_o, b.wb_data_o}, {1'b1, 8'h53, 32'd4});
        step();
        u_flip = '0;
        step();

        // asynchronous reset while a DIV is outstanding
        b.hz_rs1_idx_i = 5'd12;
        req(8'h61, OP_NONE, OP_DIV, 32'd1000, 32'd10, 5'd12);
        step(5);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_hazard", b.hazard_o, 0);
        chk("t6_rst_pins", {b.uid_d2_o, b.mul_op_o, b.div_op_o, b.mu_rs1_o, b.mu_rs2_o, b.rf_dst_idu_o},
            {8'h00, 4'h0, 4'h0, 32'd0, 32'd0, 5'd0});
        chk("t6_rst_wb", {b.wb_valid_o, b.wb_dst_o, b.wb_uid_o}, 0);
        chk("t6_rst_ready", b.req_ready_o, 1);
        step(2);
        @(negedge clk); resetn = 1'b1;
        step();
        @(negedge clk); chk("t6_ready_after", b.req_ready_o, 1);
        step();
        req(8'h71, OP_MUL, OP_NONE, 32'hFFFF_FFFC, 32'hFFFF_FFFB, 5'd13);
        step(3);
        @(negedge clk); chk("t6_post_mul", {b.wb_valid_o, b.wb_data_o, b.wb_uid_o}, {1'b1, 32'd20, 8'h71});
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
